writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
- Writeback-end consumer of the MEM/WB pipeline register in the 16-bit CPU.
- Selects the result (memory data or calculated data), commits it to a 16-entry x 16-bit register file, and serves two combinational decode read ports.
- Counts retired instructions.
- Provides a sequential register-dump engine that streams all registers to a debug/UART sink over a valid/ready handshake.

Parameters:
- DATA_W, 16, register and data width
- NREGS, 16, number of architectural registers (power of two)
- ADDR_W, 4, log2(NREGS)
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wbs_in  in  1  writeback select: 1 = memData_in, 0 = calcData_in
- memData_in  in  DATA_W  load data from MEM/WB
- calcData_in  in  DATA_W  ALU/calculated data from MEM/WB
- ni_in  in  1  no-instruction (bubble) flag: 1 = slot empty, nothing commits
- reg_dest_in  in  1  write-enable: 1 = instruction writes a register
- reg_dest_data_writeback_in  in  ADDR_W  destination register index
- rd_addr_a  in  ADDR_W  decode read port A address
- rd_addr_b  in  ADDR_W  decode read port B address
- rd_data_a  out  DATA_W  port A data (combinational)
- rd_data_b  out  DATA_W  port B data (combinational)
- retired_cnt  out  CNT_W  count of committed non-bubble slots
- dump_start  in  1  single-cycle pulse that starts a register dump
- dump_valid  out  1  dump_data/dump_idx hold a valid beat
- dump_ready  in  1  sink accepts the beat
- dump_data  out  DATA_W  register contents
- dump_idx  out  ADDR_W  index of the register in dump_data
- dump_busy  out  1  dump engine not IDLE

Behaviour:
- Reset (async, rst_n=0): all registers cleared to 0x0000; retired_cnt=0; FSM=IDLE; dump_valid=0, dump_busy=0, dump_data=0, dump_idx=0.
- Write value: wdata = wbs_in ? memData_in : calcData_in.
- Commit condition: commit = !ni_in && reg_dest_in. On commit, regs[reg_dest_data_writeback_in] <= wdata at the rising edge; visible in regs the next cycle.
- Register 0 is writable (no hardwired zero).
- Retire count: retired_cnt increments by 1 on every edge with ni_in=0, regardless of reg_dest_in. It wraps from 2^CNT_W-1 to 0.
- Read ports: combinational from the register array, with bypass behaviour per the optional feature below.
- Dump FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE: a cycle with dump_start=1 sets idx=0 and goes to LOAD; dump_start is ignored in all other states.
  - LOAD: dump_data <= regs[idx] and dump_idx <= idx; dump_valid <= 1; go to SEND.
  - SEND: hold dump_valid, dump_data and dump_idx stable until dump_ready=1. On the handshake edge (valid && ready), dump_valid <= 0. If idx == NREGS-1 go to DONE; otherwise idx <= idx+1 and go to LOAD.
  - DONE: one cycle, then IDLE.
  - Throughput: one beat per 2 cycles at best.
- Snapshot: each value is sampled in LOAD. A commit in the same cycle as LOAD to the same index is not seen; the old value is dumped.
- dump_busy = (state != IDLE).
- Commits and the retire count are never stalled by the dump engine.
- Reset mid-dump: immediate return to IDLE; dump_valid drops asynchronously.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when commit=1 and rd_addr_x == reg_dest_data_writeback_in, rd_data_x = wdata in the same cycle (write-through forwarding), for both ports independently.
- Undefined: read ports return stored array contents only; same-cycle reads of the written register return the old value.

Test Plan:
- Reset: hold rst_n=0 mid-cycle with prior nonzero state -> all rd_data=0x0000, retired_cnt=0, dump_valid=0, dump_busy=0 immediately.
- Write select: wbs_in=1, memData_in=0xBEEF, calcData_in=0x1234, reg_dest_in=1, dest=5, ni_in=0 -> next cycle rd_data_a(5)=0xBEEF. Repeat with wbs_in=0 to dest 6 -> rd_data_b(6)=0x1234. retired_cnt=2.
- Bubble/no-write:
  - ni_in=1, reg_dest_in=1, dest=5, data 0xAAAA -> reg5 stays 0xBEEF, retired_cnt unchanged.
  - ni_in=0, reg_dest_in=0 -> reg unchanged, retired_cnt+1.
- Bypass: commit 0x5A5A to reg 3 with rd_addr_a=3 in the same cycle -> rd_data_a=0x5A5A that cycle with WB_BYPASS_EN; old value without it.
- Dump with backpressure: preload regs[i]=0x1000+i, pulse dump_start, hold dump_ready=0 for 5 cycles on beat 0 -> dump_data=0x1000, dump_idx=0 held stable. Then ready=1 -> 16 beats in index order 0..15, dump_busy falls 1 cycle after beat 15. A dump_start during the dump is ignored.
- Counter wrap: CNT_W=4, 17 non-bubble slots -> retired_cnt=1.

Source files
------------

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback select, 16x16 register file, retire counter and register-dump engine
// Optional write-through read forwarding is enabled by defining WB_BYPASS_EN.
module writeback_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_in,
  input  logic [DATA_W-1:0] memData_in,
  input  logic [DATA_W-1:0] calcData_in,
  input  logic              ni_in,
  input  logic              reg_dest_in,
  input  logic [ADDR_W-1:0] reg_dest_data_writeback_in,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [CNT_W-1:0]  retired_cnt,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_idx,
  output logic              dump_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] wdata;
  logic              commit;

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] didx_q, didx_d;

  assign wdata  = wbs_in ? memData_in : calcData_in;
  assign commit = !ni_in && reg_dest_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[reg_dest_data_writeback_in] <= wdata;
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
    if (commit && (rd_addr_a == reg_dest_data_writeback_in)) begin
      rd_data_a = wdata;
    end
    if (commit && (rd_addr_b == reg_dest_data_writeback_in)) begin
      rd_data_b = wdata;
    end
  end
`else
  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];
`endif

  // Every occupied slot retires, whether or not it writes a register.
  always_comb begin
    cnt_d = cnt_q;
    if (!ni_in) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;

  // Dump engine: the register is sampled in LOAD, so a same-cycle commit is not seen.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    didx_d  = didx_q;
    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        data_d  = regs_q[idx_q];
        didx_d  = idx_q;
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (valid_q && dump_ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      didx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      didx_q  <= didx_d;
    end
  end

  assign dump_valid = valid_q;
  assign dump_data  = data_q;
  assign dump_idx   = didx_q;
  assign dump_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - self-checking bench for writeback_regfile
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_in = 1'b0;
  logic [15:0] memData_in = '0;
  logic [15:0] calcData_in = '0;
  logic        ni_in = 1'b1;
  logic        reg_dest_in = 1'b0;
  logic [3:0]  dest = '0;
  logic [3:0]  rd_addr_a = '0;
  logic [3:0]  rd_addr_b = '0;
  logic        dump_start = 1'b0;
  logic        dump_ready = 1'b0;

  logic [15:0] rd_data_a, rd_data_b, dump_data;
  logic [31:0] retired_cnt;
  logic        dump_valid, dump_busy;
  logic [3:0]  dump_idx;

  logic [15:0] rd_data_a4, rd_data_b4, dump_data4;
  logic [3:0]  retired_cnt4;
  logic        dump_valid4, dump_busy4;
  logic [3:0]  dump_idx4;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_regs [16];
  logic [31:0] m_cnt;
  int          beat_cnt = 0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_data;
  logic [3:0]  prev_idx;

  always #5 clk = ~clk;

  writeback_regfile u_dut (
    .clk(clk), .rst_n(rst_n), .wbs_in(wbs_in), .memData_in(memData_in),
    .calcData_in(calcData_in), .ni_in(ni_in), .reg_dest_in(reg_dest_in),
    .reg_dest_data_writeback_in(dest), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .retired_cnt(retired_cnt),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_idx(dump_idx), .dump_busy(dump_busy)
  );

  writeback_regfile #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .wbs_in(wbs_in), .memData_in(memData_in),
    .calcData_in(calcData_in), .ni_in(ni_in), .reg_dest_in(reg_dest_in),
    .reg_dest_data_writeback_in(dest), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a4), .rd_data_b(rd_data_b4), .retired_cnt(retired_cnt4),
    .dump_start(dump_start), .dump_valid(dump_valid4), .dump_ready(dump_ready),
    .dump_data(dump_data4), .dump_idx(dump_idx4), .dump_busy(dump_busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: registers and retire count follow the commit rules directly.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
      m_cnt = 0;
    end else begin
      if (!ni_in && reg_dest_in) m_regs[dest] = wbs_in ? memData_in : calcData_in;
      if (!ni_in) m_cnt = m_cnt + 1;
    end
  end

  function automatic logic [15:0] exp_read(input logic [3:0] addr);
    logic [15:0] v;
    v = m_regs[addr];
`ifdef WB_BYPASS_EN
    if (!ni_in && reg_dest_in && addr == dest) v = wbs_in ? memData_in : calcData_in;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    check("rd_a", rd_data_a, exp_read(rd_addr_a));
    check("rd_b", rd_data_b, exp_read(rd_addr_b));
    check("rd_a_w4", rd_data_a4, exp_read(rd_addr_a));
    check("rd_b_w4", rd_data_b4, exp_read(rd_addr_b));
    check("retired", retired_cnt, m_cnt);
    check("retired_w4", retired_cnt4, m_cnt % 16);
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", dump_valid, 1);
        check("hold_data", dump_data, prev_data);
        check("hold_idx", dump_idx, prev_idx);
      end
      if (dump_start && !dump_busy) beat_cnt = 0;
      if (dump_valid && dump_ready) begin
        check("beat_idx", dump_idx, beat_cnt[3:0]);
        check("beat_data", dump_data, m_regs[beat_cnt[3:0]]);
        beat_cnt++;
      end
      prev_hold = dump_valid && !dump_ready;
      prev_data = dump_data;
      prev_idx  = dump_idx;
    end
  end

  task automatic step(input logic wbs, input logic [15:0] mem, input logic [15:0] calc,
                      input logic ni, input logic rdest, input logic [3:0] d);
    wbs_in = wbs; memData_in = mem; calcData_in = calc;
    ni_in = ni; reg_dest_in = rdest; dest = d;
    @(posedge clk); #1;
    ni_in = 1'b1; reg_dest_in = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    step(1'b1, 16'hBEEF, 16'h1234, 1'b0, 1'b1, 4'd5);
    rd_addr_a = 4'd5; #1;
    check("wsel_mem", rd_data_a, 16'hBEEF);
    step(1'b0, 16'hBEEF, 16'h1234, 1'b0, 1'b1, 4'd6);
    rd_addr_b = 4'd6; #1;
    check("wsel_calc", rd_data_b, 16'h1234);
    check("retired_2", retired_cnt, 2);

    step(1'b0, 16'hAAAA, 16'hAAAA, 1'b1, 1'b1, 4'd5);
    #1;
    check("bubble_reg", rd_data_a, 16'hBEEF);
    check("bubble_cnt", retired_cnt, 2);
    step(1'b0, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 4'd5);
    #1;
    check("nowrite_reg", rd_data_a, 16'hBEEF);
    check("nowrite_cnt", retired_cnt, 3);

    rd_addr_a = 4'd3;
    wbs_in = 1'b0; calcData_in = 16'h5A5A; ni_in = 1'b0; reg_dest_in = 1'b1; dest = 4'd3;
    #2;
`ifdef WB_BYPASS_EN
    check("bypass_same", rd_data_a, 16'h5A5A);
`else
    check("bypass_same", rd_data_a, 16'h0000);
`endif
    @(posedge clk); #1;
    ni_in = 1'b1; reg_dest_in = 1'b0; #1;
    check("bypass_next", rd_data_a, 16'h5A5A);

    for (int i = 0; i < 16; i++) step(1'b1, 16'h1000 + 16'(i), 16'h0, 1'b0, 1'b1, 4'(i));

    ni_in = 1'b0; reg_dest_in = 1'b0; dump_ready = 1'b0;
    dump_start = 1'b1;
    @(posedge clk); #1 dump_start = 1'b0;
    @(posedge clk); #1;
    check("dump_first_valid", dump_valid, 1);
    check("dump_first_data", dump_data, 16'h1000);
    check("dump_first_idx", dump_idx, 0);
    for (int i = 0; i < 5; i++) begin
      dump_start = (i == 2);
      @(posedge clk); #1;
      check("bp_data", dump_data, 16'h1000);
      check("bp_idx", dump_idx, 0);
    end
    dump_start = 1'b0;
    dump_ready = 1'b1;
    n = 0;
    while (beat_cnt < 16 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("dump_beats", beat_cnt, 16);
    #1;
    check("busy_after_last", dump_busy, 1);
    check("valid_after_last", dump_valid, 0);
    @(posedge clk); #1;
    check("busy_idle", dump_busy, 0);
    dump_ready = 1'b0;
    ni_in = 1'b1;

    dump_start = 1'b1;
    @(posedge clk); #1 dump_start = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_valid", dump_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", dump_valid, 0);
    check("rst_busy", dump_busy, 0);
    check("rst_cnt", retired_cnt, 0);
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i); #1;
      check("rst_rd_a", rd_data_a, 16'h0000);
      check("rst_rd_b", rd_data_b, 16'h0000);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 17; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 4'd0);
    #1;
    check("wrap_cnt4", retired_cnt4, 1);
    check("wrap_cnt32", retired_cnt, 17);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
